fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port pc  input  32  current program counter from the PC register.
REQ-005 The block SHALL have port insStall  output  1  instruction-issue stall to the PC register; 1 = hold pc.
REQ-006 The block SHALL have port pcWrite  output  1  pc update enable to the PC register.
REQ-007 The block SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 The block SHALL have port imem_addr  output  32  instruction memory word address (byte address, equals pc).
REQ-009 The block SHALL have port imem_rdata  input  32  instruction memory read data, valid exactly one cycle after imem_req.
REQ-010 The block SHALL have port flush  input  1  redirect/mispredict flush from branch resolution.
REQ-011 The block SHALL have port issue_valid  output  1  head entry available to the issue stage.
REQ-012 The block SHALL have port issue_ins  output  32  instruction word of head entry.
REQ-013 The block SHALL have port issue_pc  output  32  pc of head entry.
REQ-014 The block SHALL have port issue_ready  input  1  issue stage (reservation station dispatch) accepts head entry this cycle.

Function
REQ-015 State: DEPTH-entry FIFO of {pc, ins}; head/tail pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits; inflight flag; inflight_pc register (32).
REQ-016 insStall SHALL be combinational: 1 when count + inflight >= DEPTH, else 0.
REQ-017 imem_req SHALL be combinational: !insStall && !flush; imem_addr SHALL equal pc at all times.
REQ-018 pcWrite SHALL equal imem_req, so the PC register advances exactly once per issued fetch.
REQ-019 Each rising edge: inflight <= imem_req; inflight_pc <= pc when imem_req = 1.
REQ-020 Push: when inflight = 1 and flush = 0, {inflight_pc, imem_rdata} SHALL be written at tail and tail incremented modulo DEPTH.
REQ-021 Pop: when issue_valid = 1, issue_ready = 1 and flush = 0, head SHALL increment modulo DEPTH.
REQ-022 issue_valid SHALL be (count != 0); issue_ins/issue_pc SHALL be combinational reads of the head entry (zero-latency, FWFT).
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push alone +1; pop alone -1.
REQ-024 Full: the stall rule (REQ-016) guarantees no push when count = DEPTH; push into a full queue SHALL never occur.
REQ-025 Empty: issue_ready while count = 0 SHALL have no effect; a push into an empty queue SHALL become visible on issue_* the following cycle (fetch-to-issue latency 2 cycles).
REQ-026 Flush (synchronous, highest priority): count, head, tail, inflight SHALL clear to 0 on the edge; the in-flight response SHALL be discarded; concurrent pop/push SHALL be ignored; imem_req = pcWrite = 0 during the flush cycle.
REQ-027 Pointer wrap-around SHALL be silent; FIFO entry contents need no clearing on flush or wrap.
REQ-028 issue_ready with issue_valid = 0 and X on issue_ins/issue_pc when empty SHALL NOT be relied upon; outputs SHALL hold the stale head entry (no X after reset).

Reset
REQ-029 On nRST = 0 (asynchronous): count = 0, head = tail = 0, inflight = 0, inflight_pc = 0, all FIFO entries = 0; hence issue_valid = 0, issue_ins = 0, issue_pc = 0, insStall = 0.
REQ-030 While nRST = 0, imem_req/pcWrite SHALL follow REQ-017/018 combinationally but no state SHALL change; reset mid-fetch SHALL discard the in-flight response.

Verification
REQ-031 Streaming: pc 0,4,8,... one per cycle, issue_ready = 1 -> issue_pc 0,4,8 in order, 2 cycles after fetch, insStall never 1.
REQ-032 Backpressure: issue_ready = 0, DEPTH = 4 -> insStall rises when count + inflight = 4 (after 4 fetches), pcWrite = 0, pc held; release issue_ready -> fetch resumes next cycle, no entry lost or duplicated.
REQ-033 Simultaneous push/pop at count = 3 -> count stays 3, order preserved across pointer wrap (tail 3->0).
REQ-034 Flush with count = 3 and inflight = 1 -> next cycle issue_valid = 0, count = 0; following fetch at redirected pc 0x40 issues as first entry.
REQ-035 Async reset asserted mid-stream -> outputs zero immediately without clock edge; after release, first fetch at pc = 0 issues issue_pc = 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches from imem at the PC register's address, buffers
// {pc, ins} pairs in a first-word-fall-through FIFO and presents the head to issue.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] pc,
    output logic        insStall,
    output logic        pcWrite,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        issue_valid,
    output logic [31:0] issue_ins,
    output logic [31:0] issue_pc,
    input  logic        issue_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          inflight;
    logic [31:0]   inflight_pc;

    logic [AW:0]   occupancy;
    logic          push;
    logic          pop;

    // An in-flight fetch already owns a slot, so it counts toward the stall level;
    // that reservation is what makes a push into a full queue impossible.
    assign occupancy = count + {{AW{1'b0}}, inflight};
    assign insStall  = (occupancy >= FULL_LEVEL);
    assign imem_req  = !insStall && !flush;
    assign pcWrite   = imem_req;
    assign imem_addr = pc;

    // Issue port: the head entry transfers on a cycle where issue_valid and
    // issue_ready are both high; issue_valid never depends on issue_ready.
    assign issue_valid = (count != '0);
    assign issue_pc    = fifo[head].pc;
    assign issue_ins   = fifo[head].ins;

    assign push = inflight && !flush;
    assign pop  = issue_valid && issue_ready && !flush;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    fifo[tail] <= '{pc: inflight_pc, ins: imem_rdata};
                    tail       <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
